// File: rtl/ps2_cmd_if.sv
// ps2_cmd_if: command request and receiver byte stream shared between a host client and ps2_cmd_ctrl
//   cmd_valid/cmd_ready/cmd_byte/cmd_has_arg/cmd_arg : command handshake (client -> controller)
//   rx_valid/rx_byte                                  : byte stream from the existing PS/2 receiver
//   rx_en                                             : receiver enable, low while the host owns the bus
//   done/err                                          : end-of-command pulse and its result code
interface ps2_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_en;
    logic       done;
    logic [1:0] err;
    modport master (
        output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, rx_valid, rx_byte,
        input  cmd_ready, rx_en, done, err
    );
    modport slave (
        input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, rx_valid, rx_byte,
        output cmd_ready, rx_en, done, err
    );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: host-to-device PS/2 command sequencer (inhibit, serialise, line-ack, FA/FE response)
//   clk, rst_n              : system clock, asynchronous active-low reset
//   ps2clk_in, ps2data_in   : raw PS/2 lines (asynchronous, synchronised here)
//   ps2clk_oe, ps2data_oe   : 1 = pull the open-drain line low
//   bus (ps2_cmd_if.slave)  : command handshake, receiver byte stream, rx_en, done/err
//   err codes: 0 ok, 1 timeout, 2 no line-ack, 3 FE retries exhausted
//   PS2_BAT_EN: when defined, a reset (FF) command runs automatically out of reset and
//   completes only after the device reports AA (self-test passed) or FC (failed).
module ps2_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RETRY_MAX      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2clk_in,
    input  logic ps2data_in,
    output logic ps2clk_oe,
    output logic ps2data_oe,
    ps2_cmd_if.slave bus
);
`ifdef PS2_BAT_EN
    localparam logic BAT_EN = 1'b1;
`else
    localparam logic BAT_EN = 1'b0;
`endif
    localparam int TW = $clog2(10 * TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_BAT  = TW'(10 * TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] INH_LIM = TW'(INHIBIT_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, TX, LACK, RESP} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d, arg_q, arg_d;
    logic has_arg_q, has_arg_d, first_q, first_d;
    logic [RW-1:0] retry_q, retry_d;
    logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic done_q, done_d;
    logic [1:0] err_q, err_d;
    logic bat_q, bat_d, aa_wait_q, aa_wait_d;
    logic [2:0] ck_sync_q, ck_sync_d;
    logic [1:0] dt_sync_q, dt_sync_d;
    logic fall, expire, accept;
    // ck_sync_q[2] is the previous synchronised level, so fall aligns with dt_sync_q[1]
    assign fall   = ck_sync_q[2] & ~ck_sync_q[1];
    assign expire = (state_q != IDLE) && (to_q == (aa_wait_q ? TO_BAT : TO_LIM));
    assign accept = bus.cmd_valid & bus.cmd_ready;
    assign ps2clk_oe     = clk_oe_q;
    assign ps2data_oe    = data_oe_q;
    assign bus.cmd_ready = (state_q == IDLE) & ~done_q;
    assign bus.rx_en     = (state_q == IDLE) | (state_q == RESP);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BAT_EN ? INHIBIT : IDLE;
            to_q      <= '0;
            bit_q     <= '0;
            byte_q    <= BAT_EN ? 8'hFF : 8'h00;
            arg_q     <= '0;
            has_arg_q <= 1'b0;
            first_q   <= 1'b1;
            retry_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            bat_q     <= BAT_EN;
            aa_wait_q <= 1'b0;
            ck_sync_q <= '1;
            dt_sync_q <= '1;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            arg_q     <= arg_d;
            has_arg_q <= has_arg_d;
            first_q   <= first_d;
            retry_q   <= retry_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bat_q     <= bat_d;
            aa_wait_q <= aa_wait_d;
            ck_sync_q <= ck_sync_d;
            dt_sync_q <= dt_sync_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        arg_d     = arg_q;
        has_arg_d = has_arg_q;
        first_d   = first_q;
        retry_d   = retry_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = err_q;
        bat_d     = bat_q;
        aa_wait_d = aa_wait_q;
        ck_sync_d = {ck_sync_q[1:0], ps2clk_in};
        dt_sync_d = {dt_sync_q[0], ps2data_in};
        if (expire) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 2'd1;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_d   = INHIBIT;
                    byte_d    = bus.cmd_byte;
                    arg_d     = bus.cmd_arg;
                    has_arg_d = bus.cmd_has_arg;
                    first_d   = 1'b1;
                    retry_d   = '0;
                end
                INHIBIT: if (to_q == INH_LIM) state_d = REQ;
                REQ: begin
                    state_d = TX;
                    bit_d   = '0;
                end
                // falls 1-8 data LSB first, fall 9 odd parity, fall 10 releases for the stop bit
                TX: if (fall) begin
                    bit_d     = bit_q + 4'd1;
                    data_oe_d = ~bit_q[3] ? ~byte_q[bit_q[2:0]] : (bit_q == 4'd8) & ^byte_q;
                    if (bit_q == 4'd9) state_d = LACK;
                end
                LACK: if (fall) begin
                    state_d = dt_sync_q[1] ? IDLE : RESP;
                    done_d  = dt_sync_q[1];
                    err_d   = dt_sync_q[1] ? 2'd2 : err_q;
                end
                RESP: if (bus.rx_valid) begin
                    if (aa_wait_q) begin
                        if (bus.rx_byte == 8'hAA || bus.rx_byte == 8'hFC) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = {1'b0, bus.rx_byte == 8'hFC};
                        end
                    end else if (bus.rx_byte == 8'hFA) begin
                        if (first_q & has_arg_q) begin
                            state_d = INHIBIT;
                            byte_d  = arg_q;
                            first_d = 1'b0;
                            retry_d = '0;
                        end else if (bat_q) begin
                            aa_wait_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = 2'd0;
                        end
                    end else if (bus.rx_byte == 8'hFE) begin
                        if (retry_q < RW'(RETRY_MAX)) begin
                            state_d = INHIBIT;
                            retry_d = retry_q + RW'(1);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = 2'd3;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) begin
            bat_d     = 1'b0;
            aa_wait_d = 1'b0;
        end
        // start bit is pulled in REQ while the clock is still held, so each cycle changes one line
        data_oe_d = (state_d == REQ) | ((state_d == TX) & data_oe_d);
        clk_oe_d  = (state_d == INHIBIT) | (state_d == REQ);
        to_d = (state_d != state_q || state_q == IDLE || (fall && (state_q == TX || state_q == LACK)) ||
                (aa_wait_d && !aa_wait_q)) ? '0 : to_q + TW'(1);
    end
endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb_ps2_cmd_ctrl: table-driven scoreboard bench for ps2_cmd_ctrl with a clocking PS/2 device model
module tb_ps2_cmd_ctrl;
`ifdef PS2_BAT_EN
    localparam bit BAT = 1'b1;
`else
    localparam bit BAT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;
    int n_chk = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    logic [10:0] exp_fr[$];
    logic [1:0] exp_err[$];
    logic [2:0] done_evq[$];
    typedef struct {
        string name;
        logic [7:0] cmd;
        logic has_arg;
        logic [7:0] arg;
        logic ack;
        int nfr;
        logic [3:0][7:0] fb;
        logic [3:0][7:0] resp;
        logic [1:0] err;
    } vec_t;
    vec_t vecs[6];
    ps2_cmd_if bus();
    assign ps2clk_in  = ~ps2clk_oe & dev_clk;
    assign ps2data_in = ~ps2data_oe & dev_data;
    ps2_cmd_ctrl #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(200), .RETRY_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n), .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.done) done_evq.push_back({bus.cmd_ready, bus.err});
        if (bus.rx_en && !bus.cmd_ready && !bus.done) rx_cnt++;
    end
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    function automatic logic [10:0] mkframe(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic rx_send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask
    task automatic send_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a);
        int t = 0;
        while (!bus.cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_byte    = c;
        bus.cmd_has_arg = ha;
        bus.cmd_arg     = a;
        @(negedge clk);
        chk("busy_after_accept", bus.cmd_ready, 0);
        bus.cmd_byte    = ~c;
        bus.cmd_has_arg = ~ha;
        bus.cmd_arg     = ~a;
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic dev_frame(input logic ack, output bit ok);
        logic [10:0] fr;
        int t = 0;
        ok = 1'b0;
        fr = '0;
        while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_start: no start bit within 3000 cycles");
            return;
        end
        repeat (10) @(negedge clk);
        fr[0] = ps2data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            fr[i] = ps2data_in;
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        if (ack) dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        if (exp_fr.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_extra: got %b with none expected", fr);
        end else chk("frame", fr, exp_fr.pop_front());
        ok = 1'b1;
    endtask
    task automatic respond(input logic [7:0] b);
        int t = 0;
        while (!bus.rx_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rx_en_resp", bus.rx_en, 1);
        rx_send(8'h33);
        rx_send(b);
    endtask
    task automatic wait_done(input string name);
        logic [2:0] g;
        int t = 0;
        while (done_evq.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_evq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_done: no done pulse within 3000 cycles", name);
            if (exp_err.size() != 0) void'(exp_err.pop_front());
        end else begin
            g = done_evq.pop_front();
            if (exp_err.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_done: unexpected done err %0d", name, g[1:0]);
            end else chk({name, "_err"}, g[1:0], exp_err.pop_front());
            chk({name, "_ready_in_done"}, g[2], 0);
        end
        repeat (2) @(negedge clk);
        chk({name, "_single_done"}, done_evq.size(), 0);
        chk({name, "_ready_after"}, bus.cmd_ready, 1);
        chk({name, "_lines_released"}, {ps2clk_oe, ps2data_oe}, 0);
    endtask
    task automatic run_vec(input vec_t v);
        bit ok;
        int rx0;
        for (int k = 0; k < v.nfr; k++) exp_fr.push_back(mkframe(v.fb[k]));
        exp_err.push_back(v.err);
        rx0 = rx_cnt;
        send_cmd(v.cmd, v.has_arg, v.arg);
        for (int k = 0; k < v.nfr; k++) begin
            dev_frame(v.ack, ok);
            if (!ok) break;
            if (v.ack) respond(v.resp[k]);
        end
        wait_done(v.name);
        chk({v.name, "_rx_en_busy"}, rx_cnt != rx0, v.ack);
        exp_fr.delete();
    endtask
    task automatic bat_seq();
        bit ok;
        exp_fr.push_back(mkframe(8'hFF));
        exp_err.push_back(2'd0);
        chk("bat_ready_low", bus.cmd_ready, 0);
        dev_frame(1'b1, ok);
        respond(8'hFA);
        repeat (10) @(negedge clk);
        chk("bat_wait_aa", {bus.cmd_ready, done_evq.size() != 0}, 0);
        rx_send(8'hAA);
        wait_done("bat");
        exp_fr.delete();
    endtask
    initial begin
        int t, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_byte = '0;
        bus.cmd_has_arg = 1'b0;
        bus.cmd_arg = '0;
        bus.rx_valid = 1'b0;
        bus.rx_byte = '0;
        vecs[0] = '{"ed_led", 8'hED, 1'b1, 8'h07, 1'b1, 2, {8'h00, 8'h00, 8'h07, 8'hED}, {8'h00, 8'h00, 8'hFA, 8'hFA}, 2'd0};
        vecs[1] = '{"fe_fe_fa", 8'hF4, 1'b0, 8'h00, 1'b1, 3, {8'h00, 8'hF4, 8'hF4, 8'hF4}, {8'h00, 8'hFA, 8'hFE, 8'hFE}, 2'd0};
        vecs[2] = '{"fe_x3", 8'hF4, 1'b0, 8'h00, 1'b1, 3, {8'h00, 8'hF4, 8'hF4, 8'hF4}, {8'h00, 8'hFE, 8'hFE, 8'hFE}, 2'd3};
        vecs[3] = '{"no_lack", 8'hF3, 1'b1, 8'h0A, 1'b0, 1, {8'h00, 8'h00, 8'h00, 8'hF3}, {8'h00, 8'h00, 8'h00, 8'h00}, 2'd2};
        vecs[4] = '{"arg_retry", 8'hED, 1'b1, 8'h02, 1'b1, 3, {8'h00, 8'h02, 8'h02, 8'hED}, {8'h00, 8'hFA, 8'hFE, 8'hFA}, 2'd0};
        vecs[5] = '{"f5_plain", 8'hF5, 1'b0, 8'h00, 1'b1, 1, {8'h00, 8'h00, 8'h00, 8'hF5}, {8'h00, 8'h00, 8'h00, 8'hFA}, 2'd0};
        repeat (3) @(negedge clk);
        chk("rst_lines", {ps2clk_oe, ps2data_oe}, 0);
        chk("rst_cmd_ready", bus.cmd_ready, !BAT);
        chk("rst_rx_en", bus.rx_en, !BAT);
        chk("rst_done_err", {bus.done, bus.err}, 0);
        rst_n = 1'b1;
`ifdef PS2_BAT_EN
        bat_seq();
`else
        repeat (300) @(negedge clk);
        chk("no_unsolicited_lines", {ps2clk_oe, ps2data_oe}, 0);
        chk("idle_ready", bus.cmd_ready, 1);
        rx_send(8'hFA);
        repeat (5) @(negedge clk);
        chk("idle_rx_ignored", {done_evq.size() != 0, bus.cmd_ready}, 1);
`endif
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        exp_err.push_back(2'd1);
        send_cmd(8'hF4, 1'b0, 8'h00);
        t = 0;
        while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (!bus.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 200);
        chk("timeout_lines", {ps2clk_oe, ps2data_oe}, 0);
        wait_done("timeout");
        send_cmd(8'hF4, 1'b0, 8'h00);
        t = 0;
        while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        chk("tx_bit_driven", {ps2clk_oe, ps2data_oe}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lines", {ps2clk_oe, ps2data_oe}, 0);
        chk("async_rst_ready", bus.cmd_ready, !BAT);
        chk("async_rst_rx_en", bus.rx_en, !BAT);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", done_evq.size(), 0);
`ifdef PS2_BAT_EN
        bat_seq();
`else
        chk("post_rst_ready", bus.cmd_ready, 1);
        chk("post_rst_rx_en", bus.rx_en, 1);
`endif
        run_vec(vecs[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
